shield_sprite_ctrl: RTL and testbench
=====================================

Name: shield_sprite_ctrl

Overview:
Sequences the tank shield power-up and drives the shield sprite ROM and shield palette lookup for the VGA pixel pipeline. It holds the shield lifetime state machine: activation, per-frame countdown, and blinking in the final frames. For each scanned pixel it performs the bounding-box hit test, issues the sprite ROM address, and emits the palette index with a registered "shield pixel opaque" flag for the top-level colour mux.

Parameters:
SPRITE_W, 32, shield sprite width in pixels (power of two)
SPRITE_H, 32, shield sprite height in pixels (power of two)
DURATION_FRAMES, 600, shield lifetime in frames after activation
BLINK_FRAMES, 120, final frames during which the shield blinks (< DURATION_FRAMES)
BLINK_HALF, 8, frames per blink half-period (power of two)
TRANSPARENT_IDX, 0, palette index treated as transparent

Ports:
Clk  in  1  system/pixel clock; single clock domain
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank, once per frame
activate  in  1  one-cycle pulse: shield picked up or re-armed
tank_x  in  10  shield box left edge, screen coordinates
tank_y  in  10  shield box top edge, screen coordinates
draw_x  in  10  current pixel x
draw_y  in  10  current pixel y
pixel_valid  in  1  draw_x/draw_y are in the visible region
rom_addr  out  log2(SPRITE_W*SPRITE_H)  sprite ROM address (row-major); ROM has a 1-cycle synchronous read
rom_data  in  8  palette index returned by the ROM one cycle after rom_addr
pal_index  out  8  index to the shield palette (combinational palette)
shield_pixel  out  1  the pixel pal_index belongs to is an opaque, visible shield pixel
active  out  1  shield is currently up (ACTIVE or EXPIRING)
frames_left  out  10  remaining lifetime in frames

Behaviour:
- Reset: state=IDLE; frames_left=0, blink counter=0, latched box position=0; rom_addr=0, pal_index=0, shield_pixel=0, active=0; pipeline valid bits cleared. Reset mid-operation aborts the shield immediately, and the next cycle outputs shield_pixel=0.
- FSM states: IDLE, ACTIVE, EXPIRING.
  - IDLE -> ACTIVE on activate; frames_left := DURATION_FRAMES; blink counter := 0.
  - ACTIVE: on frame_start, frames_left -= 1. When the post-decrement value is <= BLINK_FRAMES, go to EXPIRING.
  - EXPIRING: on frame_start, frames_left -= 1 and blink counter += 1. When frames_left is 1 at frame_start, go to IDLE with frames_left := 0.
  - activate in ACTIVE or EXPIRING re-arms: -> ACTIVE, frames_left := DURATION_FRAMES, blink counter := 0.
  - activate and frame_start in the same cycle: activate wins; no decrement that frame.
- active = (state != IDLE), registered with the state.
- Position latch: tank_x/tank_y are sampled only on frame_start, so the box never tears mid-frame. After activation and before the first frame_start, the latched value from the previous frame is used.
- Visibility: vis = ACTIVE, or EXPIRING with blink phase (bit log2(BLINK_HALF) of the blink counter) == 0. The shield is therefore shown for the first BLINK_HALF frames of EXPIRING.
- Hit test (stage 0, comb -> reg):
  - hit = pixel_valid && vis && draw_x >= bx && draw_x < bx+SPRITE_W && draw_y >= by && draw_y < by+SPRITE_H.
  - Compute in 11-bit unsigned so a box past the screen edge clips without wrap.
  - rom_addr = (draw_y-by)[log2 H-1:0]*SPRITE_W + (draw_x-bx)[log2 W-1:0]; registered. On a miss, rom_addr holds its last value.
- Stage 1: hit_d <= hit (hit_d is the stage-1 delayed hit). rom_data is valid this cycle.
- Stage 2 outputs: pal_index <= rom_data; shield_pixel <= hit_d && (rom_data != TRANSPARENT_IDX).
- Total latency draw_x/draw_y -> shield_pixel/pal_index is 2 cycles. The top level delays the background pipeline to match. Throughput is 1 pixel/cycle with no stalls.
- frames_left saturates at 0 and never underflows. frame_start in IDLE is ignored apart from the position latch.

Decomposition:
- Package shield_pkg:
  - shield_state_t enum {IDLE, ACTIVE, EXPIRING}
  - sprite dimension constants
  - ROM_AW = $clog2(SPRITE_W*SPRITE_H)
  - SCREEN_W=640, SCREEN_H=480
- One sub-module: shield_life_fsm (state, frames_left, blink counter, vis, active). The hit-test/address pipeline stays in the top module. The ROM and shield palette are instantiated outside, at the top level.

Test Plan:
- Reset, then activate, then 5 frame_start pulses -> active=1, frames_left=595, state ACTIVE, no blinking.
- Run frames until frames_left=120 -> state EXPIRING.
  - Over the next 16 frames, vis pattern is 8 on / 8 off.
  - When frames_left reaches 0, active=0 and shield_pixel stays 0.
- With tank_x=100, tank_y=50, latched and active, scan draw_x=99..132 at draw_y=50:
  - rom_addr 0..31 for x=100..131.
  - shield_pixel asserted exactly 2 cycles after each x in 100..131 whose ROM value != 0.
  - Deasserted for x=99 and x=132; pixels with ROM value 0 give shield_pixel=0.
- tank_x=620 (box past the right edge): draw_x=619 -> no hit, draw_x=620..639 -> hit, no wraparound hit at draw_x=0..11.
- activate coincident with frame_start while frames_left=50 (EXPIRING) -> next cycle ACTIVE, frames_left=600, vis=1.
- Assert Reset for one cycle mid-frame while ACTIVE with hits in flight -> shield_pixel=0 the cycle after Reset, active=0, frames_left=0, and it stays idle until the next activate.

Source files
------------

// File: rtl/shield_pkg.sv
// Shared types and default geometry for the tank shield sprite block.
package shield_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EXPIRING
    } shield_state_t;

    localparam int DEF_SPRITE_W        = 32;
    localparam int DEF_SPRITE_H        = 32;
    localparam int DEF_DURATION_FRAMES = 600;
    localparam int DEF_BLINK_FRAMES    = 120;
    localparam int DEF_BLINK_HALF      = 8;
    localparam int DEF_TRANSPARENT_IDX = 0;

    localparam int ROM_AW   = $clog2(DEF_SPRITE_W * DEF_SPRITE_H);
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/shield_life_fsm.sv
// Shield lifetime sequencer: activation, per-frame countdown and end-of-life blink.
module shield_life_fsm
    import shield_pkg::*;
#(
    parameter int DURATION_FRAMES = DEF_DURATION_FRAMES,
    parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
    parameter int BLINK_HALF      = DEF_BLINK_HALF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       activate,
    output logic       active,
    output logic [9:0] frames_left,
    output logic       vis
);

    localparam int PB = $clog2(BLINK_HALF);

    shield_state_t state, state_n;
    logic [9:0]    fl_n;
    // Only the phase bit is observed, so the counter may wrap freely.
    logic [PB:0]   blink, blink_n;

    always_comb begin
        state_n = state;
        fl_n    = frames_left;
        blink_n = blink;
        if (activate) begin
            state_n = ACTIVE;
            fl_n    = 10'(DURATION_FRAMES);
            blink_n = '0;
        end else if (frame_start) begin
            unique case (state)
                IDLE: begin
                end
                ACTIVE: begin
                    fl_n = (frames_left == '0) ? '0 : frames_left - 10'd1;
                    if (fl_n <= 10'(BLINK_FRAMES)) state_n = EXPIRING;
                end
                EXPIRING: begin
                    if (frames_left <= 10'd1) begin
                        state_n = IDLE;
                        fl_n    = '0;
                        blink_n = '0;
                    end else begin
                        fl_n    = frames_left - 10'd1;
                        blink_n = blink + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            frames_left <= '0;
            blink       <= '0;
            active      <= 1'b0;
        end else begin
            state       <= state_n;
            frames_left <= fl_n;
            blink       <= blink_n;
            active      <= (state_n != IDLE);
        end
    end

    assign vis = (state == ACTIVE) || (state == EXPIRING && !blink[PB]);

endmodule

// File: rtl/shield_sprite_ctrl.sv
// Shield power-up sequencing plus the 2-cycle hit-test / sprite ROM / palette pipeline.
module shield_sprite_ctrl
    import shield_pkg::*;
#(
    parameter int SPRITE_W        = DEF_SPRITE_W,
    parameter int SPRITE_H        = DEF_SPRITE_H,
    parameter int DURATION_FRAMES = DEF_DURATION_FRAMES,
    parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
    parameter int BLINK_HALF      = DEF_BLINK_HALF,
    parameter int TRANSPARENT_IDX = DEF_TRANSPARENT_IDX
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  frame_start,
    input  logic                                  activate,
    input  logic [9:0]                            tank_x,
    input  logic [9:0]                            tank_y,
    input  logic [9:0]                            draw_x,
    input  logic [9:0]                            draw_y,
    input  logic                                  pixel_valid,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] rom_addr,
    input  logic [7:0]                            rom_data,
    output logic [7:0]                            pal_index,
    output logic                                  shield_pixel,
    output logic                                  active,
    output logic [9:0]                            frames_left
);

    localparam int WB = $clog2(SPRITE_W);
    localparam int HB = $clog2(SPRITE_H);

    logic          vis;
    logic [9:0]    bx, by;
    logic [10:0]   x_end, y_end;
    logic [WB-1:0] dx;
    logic [HB-1:0] dy;
    logic          hit, hit_r, hit_d;

    shield_life_fsm #(
        .DURATION_FRAMES (DURATION_FRAMES),
        .BLINK_FRAMES    (BLINK_FRAMES),
        .BLINK_HALF      (BLINK_HALF)
    ) u_life (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .activate    (activate),
        .active      (active),
        .frames_left (frames_left),
        .vis         (vis)
    );

    // 11-bit box edges so a box hanging off the screen clips instead of wrapping.
    assign x_end = {1'b0, bx} + 11'(SPRITE_W);
    assign y_end = {1'b0, by} + 11'(SPRITE_H);
    assign dx    = WB'(draw_x - bx);
    assign dy    = HB'(draw_y - by);

    assign hit = pixel_valid && vis
              && (draw_x >= bx) && ({1'b0, draw_x} < x_end)
              && (draw_y >= by) && ({1'b0, draw_y} < y_end);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bx           <= '0;
            by           <= '0;
            rom_addr     <= '0;
            hit_r        <= 1'b0;
            hit_d        <= 1'b0;
            pal_index    <= '0;
            shield_pixel <= 1'b0;
        end else begin
            if (frame_start) begin
                bx <= tank_x;
                by <= tank_y;
            end
            if (hit) rom_addr <= {dy, dx};
            hit_r        <= hit;
            hit_d        <= hit_r;
            pal_index    <= rom_data;
            shield_pixel <= hit_d && (rom_data != 8'(TRANSPARENT_IDX));
        end
    end

endmodule

// File: tb/tb_shield_sprite_ctrl.sv
// Self-checking bench: frame-count lifetime model plus a 2-deep pixel delay model.
module tb_shield_sprite_ctrl;

    localparam int DUR   = 600;
    localparam int BLINK = 120;
    localparam int HALF  = 8;
    localparam int SW    = 32;
    localparam int SH    = 32;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       activate = 1'b0;
    logic [9:0] tank_x = '0;
    logic [9:0] tank_y = '0;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;
    logic       pixel_valid = 1'b0;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] pal_index;
    logic       shield_pixel;
    logic       active;
    logic [9:0] frames_left;

    always #5 Clk = ~Clk;

    shield_sprite_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .activate     (activate),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .pixel_valid  (pixel_valid),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pal_index    (pal_index),
        .shield_pixel (shield_pixel),
        .active       (active),
        .frames_left  (frames_left)
    );

    // Sprite ROM with one-cycle synchronous read; every 5th texel transparent.
    logic [7:0] rom [0:1023];
    initial begin
        for (int a = 0; a < 1024; a++)
            rom[a] = (a % 5 == 0) ? 8'd0 : 8'((a * 13) % 255 + 1);
    end
    always_ff @(posedge Clk) rom_data <= rom[rom_addr];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lifetime is purely a frame count; blinking derives from it.
    int m_fl = 0, m_bx = 0, m_by = 0, m_addr = 0;
    bit m_ready = 0, prev_rst = 0;
    bit m_hit;
    bit p1_sp = 0, p2_sp = 0, e_sp = 0;
    int p1_pal = 0, p2_pal = 0, e_pal = 0;

    function automatic bit m_vis(input int fl);
        if (fl > BLINK) return 1'b1;
        if (fl == 0) return 1'b0;
        return (((BLINK - fl) / HALF) % 2) == 0;
    endfunction

    initial begin
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_fl = 0; m_bx = 0; m_by = 0; m_addr = 0;
                e_sp = 0; e_pal = 0;
                p2_sp = 0; p2_pal = p1_pal;
                p1_sp = 0; p1_pal = rom[0];
                if (prev_rst) m_ready = 1;
            end else begin
                m_hit = pixel_valid && m_vis(m_fl)
                     && int'(draw_x) >= m_bx && int'(draw_x) < m_bx + SW
                     && int'(draw_y) >= m_by && int'(draw_y) < m_by + SH;
                if (m_hit)
                    m_addr = (int'(draw_y) - m_by) * SW + (int'(draw_x) - m_bx);
                e_sp = p2_sp; e_pal = p2_pal;
                p2_sp = p1_sp; p2_pal = p1_pal;
                p1_sp = m_hit && rom[m_addr] != 0;
                p1_pal = rom[m_addr];
                if (activate) m_fl = DUR;
                else if (frame_start && m_fl > 0) m_fl = m_fl - 1;
                if (frame_start) begin
                    m_bx = tank_x;
                    m_by = tank_y;
                end
            end
            prev_rst = Reset;
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (m_ready) begin
                chk("rom_addr", rom_addr, m_addr);
                chk("frames_left", frames_left, m_fl);
                chk("active", active, m_fl > 0);
                chk("shield_pixel", shield_pixel, e_sp);
                chk("pal_index", pal_index, e_pal);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        activate    = 1'b0;
        Reset       = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
    endtask

    task automatic probe(input int x, input int y, input int exp, input string name);
        draw_x = 10'(x); draw_y = 10'(y); pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        tick();
        tick();
        chk(name, shield_pixel, exp);
    endtask

    int xs[$];
    int px;

    initial begin
        Reset = 1'b1; tick();
        Reset = 1'b1; tick();
        Reset = 1'b1; tick();
        chk("rst_active", active, 0);
        chk("rst_frames", frames_left, 0);
        chk("rst_pixel", shield_pixel, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_pal", pal_index, 0);

        tank_x = 10'd100; tank_y = 10'd50;
        frame();
        activate = 1'b1; tick();
        repeat (5) frame();
        chk("fl_595", frames_left, 595);
        chk("act_595", active, 1);

        for (int x = 99; x <= 134; x++) begin
            if (x <= 132) begin
                draw_x = 10'(x); draw_y = 10'd50; pixel_valid = 1'b1;
            end else begin
                pixel_valid = 1'b0;
            end
            tick();
            if (x >= 100 && x <= 131) chk("scan_addr", rom_addr, x - 100);
            if (x >= 101) begin
                px = x - 2;
                chk("scan_pix", shield_pixel,
                    (px >= 100 && px <= 131) ? int'(rom[px - 100] != 0) : 0);
            end
        end

        repeat (475) frame();
        chk("fl_120", frames_left, 120);
        for (int k = 0; k < 16; k++) begin
            probe(101, 50, k < 8, "blink");
            frame();
        end
        chk("fl_104", frames_left, 104);

        repeat (54) frame();
        chk("fl_50", frames_left, 50);
        activate = 1'b1; frame_start = 1'b1; tick();
        chk("rearm_fl", frames_left, 600);
        chk("rearm_act", active, 1);
        probe(101, 50, 1, "rearm_vis");

        tank_x = 10'd620; tank_y = 10'd50;
        frame();
        for (int x = 619; x <= 639; x++) xs.push_back(x);
        for (int x = 0; x <= 11; x++) xs.push_back(x);
        for (int i = 0; i < xs.size() + 2; i++) begin
            if (i < xs.size()) begin
                draw_x = 10'(xs[i]); draw_y = 10'd51; pixel_valid = 1'b1;
            end else begin
                pixel_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                px = xs[i - 2];
                chk("edge_pix", shield_pixel,
                    (px >= 620) ? int'(rom[SW + px - 620] != 0) : 0);
            end
        end

        draw_x = 10'd621; draw_y = 10'd51; pixel_valid = 1'b1; tick();
        draw_x = 10'd622; tick();
        Reset = 1'b1; tick();
        chk("rst_mid_pix", shield_pixel, 0);
        chk("rst_mid_act", active, 0);
        chk("rst_mid_fl", frames_left, 0);
        for (int k = 0; k < 4; k++) begin
            frame();
            probe(625, 55, 0, "idle_pix");
            chk("idle_act", active, 0);
        end

        tank_x = 10'd200; tank_y = 10'd100;
        frame();
        activate = 1'b1; tick();
        repeat (599) frame();
        chk("fl_1", frames_left, 1);
        chk("act_1", active, 1);
        frame();
        chk("expire_act", active, 0);
        chk("expire_fl", frames_left, 0);
        probe(205, 105, 0, "expire_pix");
        frame();
        chk("idle_sat", frames_left, 0);

        repeat (3000) begin
            Reset       = ($urandom_range(0, 999) == 0);
            activate    = ($urandom_range(0, 63) == 0);
            frame_start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                tank_x = 10'($urandom_range(0, 660));
                tank_y = 10'($urandom_range(0, 500));
            end
            draw_x = 10'(int'(tank_x) + int'($urandom_range(0, 40)) - 4);
            draw_y = 10'(int'(tank_y) + int'($urandom_range(0, 40)) - 4);
            pixel_valid = ($urandom_range(0, 7) != 0);
            tick();
        end

        activate = 1'b1; tick();
        repeat (2500) begin
            activate    = ($urandom_range(0, 4095) == 0);
            frame_start = ($urandom_range(0, 3) == 0);
            draw_x = 10'(int'(tank_x) + int'($urandom_range(0, 40)) - 4);
            draw_y = 10'(int'(tank_y) + int'($urandom_range(0, 40)) - 4);
            pixel_valid = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
